// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud detector: times the start bit and bit0 of a 0x55 sync character
// and commits a 16x-oversampling divisor when the two widths agree.
module uart_autobaud_ctrl #(
  parameter logic [15:0] DEFAULT_DIV = 16'd27,
  parameter int          MIN_BIT     = 32,
  parameter int          CNT_W       = 20
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic        Rx,
  output logic [15:0] BaudRate,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [1:0]  ErrCode
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IDLE, S_WAIT_FALL, S_MEAS_LOW, S_MEAS_HIGH, S_CHECK
  } state_e;

  localparam int             SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] W_MAX = '1;

  state_e           state_q;
  logic             sync1_q, rxs_q, rxs_dly_q;
  logic [CNT_W-1:0] w_q, l_q, h_q;
  logic [15:0]      baud_q;
  logic             busy_q, done_q, error_q;
  logic [1:0]       err_code_q;

  logic             fall_s, rise_s, mismatch_s, div_zero_s;
  logic [CNT_W-1:0] diff_s;
  logic [SUM_W-1:0] sum_s;
  logic [15:0]      div_s;

  assign fall_s     = rxs_dly_q & ~rxs_q;
  assign rise_s     = ~rxs_dly_q & rxs_q;
  assign diff_s     = (l_q >= h_q) ? (l_q - h_q) : (h_q - l_q);
  assign mismatch_s = diff_s > (l_q >> 3);
  // +16 rounds (L+H)/32 to nearest: two bit times over 16 ticks per bit, halved.
  assign sum_s      = {1'b0, l_q} + {1'b0, h_q} + SUM_W'(16);
  assign div_s      = 16'(sum_s >> 5);
  assign div_zero_s = (div_s == 16'd0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_dly_q  <= 1'b1;
      w_q        <= '0;
      l_q        <= '0;
      h_q        <= '0;
      baud_q     <= DEFAULT_DIV;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      sync1_q   <= Rx;
      rxs_q     <= sync1_q;
      rxs_dly_q <= rxs_q;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q    <= S_WAIT_IDLE;
            busy_q     <= 1'b1;
            err_code_q <= 2'd0;
          end
        end
        S_WAIT_IDLE: begin
          if (rxs_q) state_q <= S_WAIT_FALL;
        end
        S_WAIT_FALL: begin
          if (fall_s) begin
            w_q     <= CNT_W'(1);
            state_q <= S_MEAS_LOW;
          end
        end
        S_MEAS_LOW: begin
          if (rise_s) begin
            if (w_q < CNT_W'(MIN_BIT)) begin
              state_q <= S_WAIT_FALL;
            end else begin
              l_q     <= w_q;
              w_q     <= CNT_W'(1);
              state_q <= S_MEAS_HIGH;
            end
          end else if (w_q == W_MAX) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= 2'd2;
          end else begin
            w_q <= w_q + CNT_W'(1);
          end
        end
        S_MEAS_HIGH: begin
          if (fall_s) begin
            h_q     <= w_q;
            state_q <= S_CHECK;
          end else if (w_q == W_MAX) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= 2'd2;
          end else begin
            w_q <= w_q + CNT_W'(1);
          end
        end
        S_CHECK: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (mismatch_s) begin
            error_q    <= 1'b1;
            err_code_q <= 2'd1;
          end else if (div_zero_s) begin
            error_q    <= 1'b1;
            err_code_q <= 2'd3;
          end else begin
            baud_q <= div_s;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BaudRate = baud_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Error    = error_q;
  assign ErrCode  = err_code_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed bench for uart_autobaud_ctrl: vector table of low/high widths plus
// hand sequences for glitches, busy restart, reset abort and timeout.
module tb_uart_autobaud_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        Rx = 1'b1;
  logic [15:0] BaudRate;
  logic        Busy, Done, Error;
  logic [1:0]  ErrCode;

  logic        Start_t = 1'b0;
  logic        Rx_t = 1'b1;
  logic [15:0] BaudRate_t;
  logic        Busy_t, Done_t, Error_t;
  logic [1:0]  ErrCode_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] got_done, got_err, got_code, got_baud, got_busy, got_extra;

  typedef struct {
    int low;
    int high;
    bit ok;
    int code;
    int baud;
  } vec_t;
  vec_t vecs[9];

  always #5 Clk = ~Clk;

  uart_autobaud_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Rx(Rx),
    .BaudRate(BaudRate), .Busy(Busy), .Done(Done), .Error(Error), .ErrCode(ErrCode)
  );

  // Narrow width counter so the timeout path is reachable in a short run.
  uart_autobaud_ctrl #(.CNT_W(10)) dut_t (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start_t), .Rx(Rx_t),
    .BaudRate(BaudRate_t), .Busy(Busy_t), .Done(Done_t), .Error(Error_t), .ErrCode(ErrCode_t)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    Rx = v;
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_start();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_result();
    got_done = 0; got_err = 0; got_extra = 0;
    got_code = ErrCode; got_baud = BaudRate; got_busy = Busy;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done || Error) begin
        got_done = Done; got_err = Error; got_code = ErrCode;
        got_baud = BaudRate; got_busy = Busy;
        break;
      end
    end
    @(negedge Clk);
    got_extra = Done | Error;
    hold(1'b1, 20);
  endtask

  task automatic check_result(input string tag, input bit ok, input int code, input int baud);
    check({tag, " done"}, got_done, ok ? 1 : 0);
    check({tag, " error"}, got_err, ok ? 0 : 1);
    check({tag, " errcode"}, got_code, code);
    check({tag, " baudrate"}, got_baud, baud);
    check({tag, " busy at result"}, got_busy, 0);
    check({tag, " single pulse"}, got_extra, 0);
  endtask

  initial begin
    vecs[0] = '{432, 432, 1'b1, 0, 27};
    vecs[1] = '{432, 300, 1'b0, 1, 27};
    vecs[2] = '{864, 864, 1'b1, 0, 54};
    vecs[3] = '{432, 486, 1'b1, 0, 29};
    vecs[4] = '{432, 487, 1'b0, 1, 29};
    vecs[5] = '{432, 378, 1'b1, 0, 25};
    vecs[6] = '{400, 460, 1'b0, 1, 25};
    vecs[7] = '{40,  40,  1'b1, 0, 3};
    vecs[8] = '{32,  32,  1'b1, 0, 2};

    repeat (3) @(negedge Clk);
    check("reset baudrate", BaudRate, 27);
    check("reset busy", Busy, 0);
    check("reset done", Done, 0);
    check("reset error", Error, 0);
    check("reset errcode", ErrCode, 0);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);

    for (int i = 0; i < 9; i++) begin
      if (i > 0) check($sformatf("vec%0d errcode held", i), ErrCode, vecs[i-1].code);
      send_start();
      check($sformatf("vec%0d busy after start", i), Busy, 1);
      check($sformatf("vec%0d errcode cleared", i), ErrCode, 0);
      hold(1'b1, 20);
      hold(1'b0, vecs[i].low);
      hold(1'b1, vecs[i].high);
      Rx = 1'b0;
      wait_result();
      check_result($sformatf("vec%0d", i), vecs[i].ok, vecs[i].code, vecs[i].baud);
    end

    // 10-cycle glitch is discarded, then a 864-cycle sync character
    send_start();
    hold(1'b1, 20);
    hold(1'b0, 10);
    hold(1'b1, 200);
    hold(1'b0, 864);
    hold(1'b1, 864);
    Rx = 1'b0;
    wait_result();
    check_result("glitch10", 1'b1, 0, 54);

    // reset pulse while measuring the high bit
    send_start();
    hold(1'b1, 20);
    hold(1'b0, 432);
    hold(1'b1, 200);
    Rst_n = 1'b0;
    #1;
    check("midreset busy", Busy, 0);
    check("midreset baudrate", BaudRate, 27);
    check("midreset done", Done, 0);
    check("midreset error", Error, 0);
    check("midreset errcode", ErrCode, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    Rx = 1'b0;
    got_extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (Done || Error || Busy) got_extra = 1;
    end
    check("midreset no pulse after release", got_extra, 0);
    hold(1'b1, 20);

    // low of MIN_BIT-1 is a glitch; MIN_BIT exactly is accepted
    send_start();
    hold(1'b1, 20);
    hold(1'b0, 31);
    hold(1'b1, 200);
    hold(1'b0, 32);
    hold(1'b1, 32);
    Rx = 1'b0;
    wait_result();
    check_result("minbit", 1'b1, 0, 2);

    // Rx already low at Start; second Start while busy must be ignored
    hold(1'b0, 50);
    send_start();
    hold(1'b0, 100);
    hold(1'b1, 50);
    hold(1'b0, 200);
    Start = 1'b1;
    hold(1'b0, 1);
    Start = 1'b0;
    hold(1'b0, 231);
    hold(1'b1, 432);
    Rx = 1'b0;
    wait_result();
    check_result("rxlow_at_start", 1'b1, 0, 27);

    // timeout on the narrow-counter instance
    @(negedge Clk);
    Start_t = 1'b1;
    @(negedge Clk);
    Start_t = 1'b0;
    repeat (20) @(negedge Clk);
    Rx_t = 1'b0;
    got_done = 0; got_err = 0; got_code = 0; got_busy = 1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge Clk);
      if (Done_t || Error_t) begin
        got_done = Done_t; got_err = Error_t; got_code = ErrCode_t; got_busy = Busy_t;
        break;
      end
    end
    check("timeout error", got_err, 1);
    check("timeout done", got_done, 0);
    check("timeout errcode", got_code, 2);
    check("timeout busy", got_busy, 0);
    check("timeout baudrate", BaudRate_t, 27);
    Rx_t = 1'b1;
    repeat (5) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_autobaud_ctrl.md
UART_AUTOBAUD_CTRL -- requirements
Module: uart_autobaud_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 16'd27, divisor driven after reset (50 MHz, 115200 baud, 16x tick).
REQ-002 SHALL have parameter MIN_BIT, default 32, minimum accepted bit width in Clk cycles.
REQ-003 SHALL have port Clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Start  input  1  one-cycle request to begin detection.
REQ-006 SHALL have port Rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port BaudRate  output  16  divisor for the baud-rate tick generator.
REQ-008 SHALL have port Busy  output  1  high while detection is in progress.
REQ-009 SHALL have port Done  output  1  one-cycle pulse when a new BaudRate is committed.
REQ-010 SHALL have port Error  output  1  one-cycle pulse when detection fails.
REQ-011 SHALL have port ErrCode  output  2  failure cause, held until the next Start: 0 none, 1 mismatch, 2 timeout, 3 zero divisor.

Function
REQ-012 SHALL pass Rx through a 2-flop synchronizer; all edge detection SHALL use the synchronized value (rxs) and its 1-cycle delayed copy.
REQ-013 SHALL implement states IDLE, WAIT_IDLE, WAIT_FALL, MEAS_LOW, MEAS_HIGH, CHECK.
REQ-014 IDLE: Busy=0; Start=1 -> WAIT_IDLE and clear ErrCode to 0; Start while not IDLE SHALL be ignored.
REQ-015 WAIT_IDLE: rxs=1 -> WAIT_FALL, so a transfer already in progress is not measured.
REQ-016 WAIT_FALL: falling edge of rxs -> MEAS_LOW with width counter W=1.
REQ-017 MEAS_LOW: W increments each cycle rxs=0; on rising edge: W<MIN_BIT -> WAIT_FALL (glitch, no Error); else latch L=W -> MEAS_HIGH with W=1.
REQ-018 MEAS_HIGH: W increments each cycle rxs=1; on falling edge latch H=W -> CHECK. The sync character is 0x55 (start bit, then bit0=1).
REQ-019 W SHALL be 20 bits; reaching 20'hFFFFF in MEAS_LOW or MEAS_HIGH -> IDLE, Error pulse, ErrCode=2.
REQ-020 CHECK (1 cycle): mismatch if |L-H| > (L>>3), giving Error with ErrCode=1; else D=(L+H+16)>>5 (21-bit sum, 16-bit result); D==0 gives Error with ErrCode=3; else BaudRate<=D and Done pulse. All CHECK outcomes -> IDLE.
REQ-021 Done and Error SHALL assert in the cycle after CHECK, coincident with the BaudRate update; they are never high together.
REQ-022 BaudRate SHALL change only on Done; on failure it SHALL retain its previous value.
REQ-023 Busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 Rst_n=0 SHALL immediately force IDLE, BaudRate=DEFAULT_DIV, Busy=0, Done=0, Error=0, ErrCode=0, W/L/H=0, synchronizer flops=1.
REQ-025 Reset asserted mid-measurement SHALL abort with no Done or Error pulse after release.

Verification
REQ-026 Start, Rx idle, then 0x55 at 432 cycles/bit -> L=H=432, Done pulse once, BaudRate=27, Busy drops with Done.
REQ-027 Start, low 432 then high 300 cycles -> Error, ErrCode=1, BaudRate remains 27.
REQ-028 Start, 10-cycle low glitch, then valid 0x55 at 864 cycles/bit -> no Error, BaudRate=54.
REQ-029 Start, Rx held low 2^20 cycles -> Error, ErrCode=2, Busy=0.
REQ-030 Start with Rx low at Start, then release and send 0x55 at 432 cycles/bit -> first low ignored (WAIT_IDLE), BaudRate=27; second Start during Busy has no effect.
REQ-031 Rst_n pulse during MEAS_HIGH -> outputs at reset values immediately, BaudRate=27, no Done/Error afterward.
